// File: rtl/pps_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pps_sync_ctrl
// Description : PPS acquisition/lock controller. Measures PPS phase error
//               against the datapath second counter and requests realignment.
// Revision    : 1.0 - initial release
// ============================================================================
module pps_sync_ctrl #(
    parameter int ClocksPerSecond = 10000,
    parameter int CaptureWindow   = 100,
    parameter int LockCount       = 3,
    parameter int MissLimit       = 2,
    localparam int c_cw           = $clog2(ClocksPerSecond)
) (
    input  logic                   clk_tf,
    input  logic                   tf_reset,
    input  logic                   enable,
    input  logic                   pps_edge,
    input  logic [c_cw-1:0]        sec_count,
    output logic                   realign,
    output logic signed [c_cw:0]   phase_err,
    output logic                   phase_err_valid,
    output logic [1:0]             state,
    output logic                   locked,
    output logic                   holdover
);

    localparam int c_gw = $clog2(LockCount + 1);
    localparam int c_mw = $clog2(MissLimit + 1);

    localparam logic [c_cw-1:0]      c_open      = c_cw'(ClocksPerSecond - CaptureWindow);
    localparam logic [c_cw-1:0]      c_win       = c_cw'(CaptureWindow);
    localparam logic [c_cw-1:0]      c_close     = c_cw'(CaptureWindow + 1);
    localparam logic signed [c_cw:0] c_cps       = (c_cw+1)'(ClocksPerSecond);
    localparam logic [c_gw-1:0]      c_lock_last = c_gw'(LockCount - 1);
    localparam logic [c_mw-1:0]      c_miss_last = c_mw'(MissLimit - 1);

    typedef enum logic [1:0] {
        ST_ACQUIRE  = 2'd0,
        ST_VERIFY   = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_gw-1:0]       r_good_cnt;
    logic [c_mw-1:0]       r_miss_cnt;
    logic                  r_seen;
    logic                  r_realign;
    logic                  r_valid;
    logic signed [c_cw:0]  r_phase_err;
    logic                  r_locked;
    logic                  r_holdover;

    logic                  w_in_win;
    logic                  w_edge_in;
    logic                  w_edge_out;
    logic                  w_miss;
    logic signed [c_cw:0]  w_sc_ext;
    logic signed [c_cw:0]  w_err;

    assign w_in_win   = (sec_count >= c_open) || (sec_count <= c_win);
    assign w_edge_in  = pps_edge & w_in_win;
    assign w_edge_out = pps_edge & ~w_in_win;
    // An edge on the close cycle is out-of-window and pre-empts the miss.
    assign w_miss     = (sec_count == c_close) & ~r_seen & ~pps_edge;
    assign w_sc_ext   = {1'b0, sec_count};
    assign w_err      = (sec_count <= c_win) ? w_sc_ext : (w_sc_ext - c_cps);

    always_ff @(posedge clk_tf) begin
        if (tf_reset) begin
            r_state     <= ST_ACQUIRE;
            r_good_cnt  <= '0;
            r_miss_cnt  <= '0;
            r_seen      <= 1'b0;
            r_realign   <= 1'b0;
            r_valid     <= 1'b0;
            r_phase_err <= '0;
            r_locked    <= 1'b0;
            r_holdover  <= 1'b0;
        end else begin
            r_realign <= 1'b0;
            r_valid   <= 1'b0;
            if (!enable) begin
                r_state    <= ST_ACQUIRE;
                r_good_cnt <= '0;
                r_miss_cnt <= '0;
                r_seen     <= 1'b0;
                r_locked   <= 1'b0;
                r_holdover <= 1'b0;
            end else begin
                if (sec_count == c_open) r_seen <= 1'b0;
                if (w_edge_in)           r_seen <= 1'b1;

                case (r_state)
                    ST_ACQUIRE: begin
                        if (pps_edge) begin
                            r_realign  <= 1'b1;
                            r_good_cnt <= '0;
                            r_state    <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_edge_out) begin
                            r_realign  <= 1'b1;
                            r_good_cnt <= '0;
                        end else if (w_edge_in) begin
                            r_valid     <= 1'b1;
                            r_phase_err <= w_err;
                            r_good_cnt  <= r_good_cnt + 1'b1;
                            if (r_good_cnt == c_lock_last) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else if (w_miss) begin
                            r_state <= ST_ACQUIRE;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_edge_out) begin
                            r_realign  <= 1'b1;
                            r_good_cnt <= '0;
                            r_state    <= ST_VERIFY;
                            r_locked   <= 1'b0;
                        end else if (w_edge_in) begin
                            r_valid     <= 1'b1;
                            r_phase_err <= w_err;
                            r_miss_cnt  <= '0;
                        end else if (w_miss) begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                            if (r_miss_cnt == c_miss_last) begin
                                r_state    <= ST_HOLDOVER;
                                r_locked   <= 1'b0;
                                r_holdover <= 1'b1;
                            end
                        end
                    end
                    ST_HOLDOVER: begin
                        if (w_edge_out) begin
                            r_realign  <= 1'b1;
                            r_good_cnt <= '0;
                            r_state    <= ST_VERIFY;
                            r_holdover <= 1'b0;
                        end else if (w_edge_in) begin
                            r_valid     <= 1'b1;
                            r_phase_err <= w_err;
                            r_miss_cnt  <= '0;
                            r_state     <= ST_LOCKED;
                            r_locked    <= 1'b1;
                            r_holdover  <= 1'b0;
                        end
                    end
                    default: r_state <= ST_ACQUIRE;
                endcase
            end
        end
    end

    assign realign         = r_realign;
    assign phase_err       = r_phase_err;
    assign phase_err_valid = r_valid;
    assign state           = r_state;
    assign locked          = r_locked;
    assign holdover        = r_holdover;

endmodule
`default_nettype wire

// File: tb/tb_pps_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pps_sync_ctrl
// Description : Directed self-checking bench for pps_sync_ctrl with a
//               behavioural datapath phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_sync_ctrl;

    localparam int c_cps  = 2000;
    localparam int c_win  = 100;
    localparam int c_lock = 3;
    localparam int c_miss = 2;
    localparam int c_cw   = $clog2(c_cps);

    logic                  clk_tf = 1'b0;
    logic                  tf_reset;
    logic                  enable;
    logic                  pps_edge;
    logic [c_cw-1:0]       sec_count;
    logic                  realign;
    logic signed [c_cw:0]  phase_err;
    logic                  phase_err_valid;
    logic [1:0]            state;
    logic                  locked;
    logic                  holdover;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_tf = ~clk_tf;

    pps_sync_ctrl #(
        .ClocksPerSecond (c_cps),
        .CaptureWindow   (c_win),
        .LockCount       (c_lock),
        .MissLimit       (c_miss)
    ) u_dut (
        .clk_tf          (clk_tf),
        .tf_reset        (tf_reset),
        .enable          (enable),
        .pps_edge        (pps_edge),
        .sec_count       (sec_count),
        .realign         (realign),
        .phase_err       (phase_err),
        .phase_err_valid (phase_err_valid),
        .state           (state),
        .locked          (locked),
        .holdover        (holdover)
    );

    // Datapath phase counter: reloads to 2 at the end of a realign cycle.
    always @(posedge clk_tf) begin
        if (tf_reset)                            sec_count <= '0;
        else if (realign)                        sec_count <= c_cw'(2);
        else if (sec_count == c_cw'(c_cps - 1))  sec_count <= '0;
        else                                     sec_count <= sec_count + 1'b1;
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_sec(input int v, output bit ok);
        int n = 0;
        do begin
            @(negedge clk_tf);
            n++;
        end while (sec_count != c_cw'(v) && n < 3 * c_cps);
        ok = (sec_count == c_cw'(v));
        if (!ok) chk("wait_timeout", 32'(sec_count), v);
    endtask

    // Edge sampled in the cycle where sec_count == v; returns in cycle N+1.
    task automatic pulse_at(input int v);
        bit ok;
        wait_sec(v, ok);
        if (ok) pps_edge = 1'b1;
        @(negedge clk_tf);
        pps_edge = 1'b0;
    endtask

    initial begin
        bit ok;
        tf_reset = 1'b1;
        enable   = 1'b1;
        pps_edge = 1'b0;
        repeat (3) @(negedge clk_tf);
        chk("rst_state",    state, 0);
        chk("rst_realign",  realign, 0);
        chk("rst_err",      phase_err, 0);
        chk("rst_valid",    phase_err_valid, 0);
        chk("rst_locked",   locked, 0);
        chk("rst_holdover", holdover, 0);
        tf_reset = 1'b0;

        // Acquire
        pulse_at(30);
        chk("acq_realign", realign, 1);
        chk("acq_state",   state, 1);
        chk("acq_valid",   phase_err_valid, 0);
        @(negedge clk_tf);
        chk("acq_realign_once", realign, 0);

        // Lock after LockCount in-window edges
        for (int i = 0; i < c_lock; i++) begin
            pulse_at(0);
            chk("lock_valid",   phase_err_valid, 1);
            chk("lock_err",     phase_err, 0);
            chk("lock_realign", realign, 0);
            chk("lock_locked",  locked, (i == c_lock - 1) ? 1 : 0);
            chk("lock_state",   state, (i == c_lock - 1) ? 2 : 1);
        end
        @(negedge clk_tf);
        chk("valid_once", phase_err_valid, 0);
        chk("err_held",   phase_err, 0);

        // Error sign and window boundaries
        pulse_at(50);
        chk("err_pos50", phase_err, 50);
        chk("err_pos50_valid", phase_err_valid, 1);
        pulse_at(c_cps - 30);
        chk("err_neg30", phase_err, -30);
        chk("err_neg30_locked", locked, 1);
        pulse_at(c_win);
        chk("err_edge_hi", phase_err, c_win);
        chk("err_edge_hi_realign", realign, 0);
        pulse_at(c_cps - c_win);
        chk("err_edge_lo", phase_err, -c_win);
        chk("err_edge_lo_valid", phase_err_valid, 1);

        // Holdover: first close follows the edge at the open cycle, then two misses
        wait_sec(c_win + 1, ok);
        @(negedge clk_tf);
        chk("close_seen_locked", locked, 1);
        wait_sec(c_win + 1, ok);
        @(negedge clk_tf);
        chk("miss1_holdover", holdover, 0);
        chk("miss1_state", state, 2);
        wait_sec(c_win + 1, ok);
        chk("miss2_pre", holdover, 0);
        @(negedge clk_tf);
        chk("miss2_holdover", holdover, 1);
        chk("miss2_state",    state, 3);
        chk("miss2_locked",   locked, 0);
        pulse_at(0);
        chk("recov_locked",   locked, 1);
        chk("recov_holdover", holdover, 0);
        chk("recov_err",      phase_err, 0);
        chk("recov_valid",    phase_err_valid, 1);

        // Out-of-window edge relocks; edge on the close cycle beats the miss
        pulse_at(c_cps / 2);
        chk("relock_realign", realign, 1);
        chk("relock_state",   state, 1);
        chk("relock_locked",  locked, 0);
        chk("relock_valid",   phase_err_valid, 0);
        wait_sec(c_cps - c_win, ok);
        pulse_at(c_win + 1);
        chk("close_edge_realign", realign, 1);
        chk("close_edge_state",   state, 1);
        chk("close_edge_valid",   phase_err_valid, 0);

        // Reset wins over a coincident edge
        tf_reset = 1'b1;
        pps_edge = 1'b1;
        @(negedge clk_tf);
        tf_reset = 1'b0;
        pps_edge = 1'b0;
        chk("rstpri_realign", realign, 0);
        chk("rstpri_state",   state, 0);
        @(negedge clk_tf);
        chk("rstpri_no_pending", realign, 0);
        pulse_at(50);
        chk("reacq_realign", realign, 1);
        chk("reacq_valid",   phase_err_valid, 0);
        chk("reacq_state",   state, 1);

        // Disable holds the controller idle
        enable = 1'b0;
        @(negedge clk_tf);
        chk("dis_state", state, 0);
        pulse_at(60);
        chk("dis_realign", realign, 0);
        chk("dis_valid",   phase_err_valid, 0);
        chk("dis_state2",  state, 0);
        enable = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pps_sync_ctrl.md
PPS_SYNC_CTRL -- requirements
Module: pps_sync_ctrl

Interface
REQ-001 The block SHALL have parameter ClocksPerSecond, default 10000, meaning timing-clock cycles per second.
REQ-002 The block SHALL have parameter CaptureWindow, default 100, meaning the half-width of the PPS acceptance window in cycles; legal only if it is less than ClocksPerSecond/2.
REQ-003 The block SHALL have parameter LockCount, default 3, meaning the number of consecutive in-window edges needed for lock; legal if at least 1.
REQ-004 The block SHALL have parameter MissLimit, default 2, meaning the number of consecutive missed seconds before holdover; legal if at least 1.
REQ-005 Port: clk_tf  input  1  timing clock; the single clock, all logic on its rising edge.
REQ-006 Port: tf_reset  input  1  synchronous, active-high reset.
REQ-007 Port: enable  input  1  controller enable; when low, the controller is held idle.
REQ-008 Port: pps_edge  input  1  single-cycle pulse marking a cleaned, synchronized raw-PPS rising edge.
REQ-009 Port: sec_count  input  CW=$clog2(ClocksPerSecond)  the datapath phase counter, range 0..ClocksPerSecond-1.
REQ-010 Port: realign  output  1  single-cycle request for the datapath to reload its phase counter.
REQ-011 Port: phase_err  output  CW+1 signed  measured PPS phase error in cycles.
REQ-012 Port: phase_err_valid  output  1  single-cycle qualifier for phase_err.
REQ-013 Port: state  output  2  ACQUIRE=0, VERIFY=1, LOCKED=2, HOLDOVER=3.
REQ-014 Port: locked  output  1  high when state is LOCKED.
REQ-015 Port: holdover  output  1  high when state is HOLDOVER.

Function
REQ-016 Window definition: an edge is in-window when sec_count >= ClocksPerSecond-CaptureWindow or sec_count <= CaptureWindow; otherwise it is out-of-window.
REQ-017 Signed error: err = sec_count when sec_count <= CaptureWindow; otherwise err = sec_count - ClocksPerSecond.
REQ-018 Window tracking: an internal seen flag clears on the cycle sec_count == ClocksPerSecond-CaptureWindow and sets on any in-window edge.
REQ-019 Window close occurs on the cycle sec_count == CaptureWindow+1; a close with seen=0 is a miss.
REQ-020 Timing of registered outputs: for an edge sampled in cycle N, realign, phase_err and phase_err_valid assert in cycle N+1 only.
REQ-021 Datapath contract: the datapath loads sec_count := 2 at the end of the realign cycle, so sec_count reads 0 at cycle N+ClocksPerSecond.
REQ-022 ACQUIRE: any edge produces a realign pulse, clears good_cnt, and moves to VERIFY.
REQ-023 VERIFY, in-window edge: phase_err_valid pulses and good_cnt increments; reaching LockCount moves to LOCKED and sets miss_cnt=0.
REQ-024 VERIFY, other events: an out-of-window edge produces realign, sets good_cnt=0 and stays in VERIFY; a miss moves to ACQUIRE.
REQ-025 LOCKED, in-window edge: phase_err_valid pulses and miss_cnt is set to 0.
REQ-026 LOCKED, miss: miss_cnt increments; when it reaches MissLimit the state moves to HOLDOVER.
REQ-027 HOLDOVER: an in-window edge pulses phase_err_valid, moves to LOCKED and sets miss_cnt=0; misses are ignored (saturate, no wrap).
REQ-028 LOCKED or HOLDOVER, out-of-window edge: realign pulses, good_cnt=0, and the state moves to VERIFY.
REQ-029 Simultaneous events: an edge on the window-close cycle is out-of-window, and the out-of-window handling takes priority over miss handling.
REQ-030 Pulse exclusivity: realign and phase_err_valid are never asserted in the same cycle.
REQ-031 Disable: enable=0 forces ACQUIRE, clears all counters and the seen flag, suppresses pulses, and ignores pps_edge.
REQ-032 Held value: phase_err holds its last value between valid pulses.
REQ-033 Counter widths: good_cnt and miss_cnt are sized to hold LockCount and MissLimit and never wrap.

Reset
REQ-034 Reset values: with tf_reset high at a clock edge, state=ACQUIRE, realign=0, phase_err=0, phase_err_valid=0, locked=0, holdover=0, good_cnt=0, miss_cnt=0, seen=0.
REQ-035 Reset priority: tf_reset overrides every event in the same cycle, including pps_edge; reset mid-operation discards any pending pulse.

Verification (ClocksPerSecond=10000, CaptureWindow=100, LockCount=3, MissLimit=2)
REQ-036 Acquire: reset released, edge at cycle N -> realign=1 only at N+1; state=VERIFY at N+1.
REQ-037 Lock: edges every 10000 cycles after acquire -> three phase_err_valid pulses with phase_err=0; locked=1 after the third pulse.
REQ-038 Error sign: while locked, edge at sec_count=50 -> phase_err=+50; edge at sec_count=9970 -> phase_err=-30; locked stays 1.
REQ-039 Holdover: while locked, two edges suppressed -> holdover=1 in the cycle after sec_count=101 of the second missed second; next edge at sec_count=0 -> locked=1, phase_err=0.
REQ-040 Relock and priority: while locked, edge at sec_count=5000 -> realign, state=VERIFY, locked=0; edge at sec_count=101 -> realign, and no miss is counted.
REQ-041 Reset priority: pps_edge coincident with tf_reset -> no realign; state=ACQUIRE; the next edge is treated as a first acquisition.
